dds_core: RTL and testbench

- Direct digital synthesis waveform generator for the function-generator datapath.
- Runs a phase accumulator whose increment is derived from a frequency in Hz.
- Produces one of sine, square, triangle, ramp or DC as an unsigned offset-binary sample each clock.
- Its output feeds the DAC/output stage.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/dds_sine_rom.sv | 67 ++++++
 rtl/dds_core.sv | 94 +++++++++
 tb/tb_dds_core.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and elaboration-time helpers for the DDS waveform generator.
package dds_pkg;

    typedef enum logic [2:0] {
        SINE     = 3'd0,
        SQUARE   = 3'd1,
        TRIANGLE = 3'd2,
        RAMP     = 3'd3,
        DC       = 3'd4
    } wave_sel_e;

    // Hz-to-increment scale factor: round(2^(phase_width+16) / fs_hz).
    function automatic longint unsigned calc_k(input int unsigned phase_width,
                                               input longint unsigned fs_hz);
        longint unsigned num;
        num = 64'd1 << (phase_width + 32'd16);
        return (num + fs_hz / 64'd2) / fs_hz;
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Full-cycle sine table with registered read; provides the stage-1 register of the sine path.
module dds_sine_rom
    import dds_pkg::*;
#(
    parameter int LUT_ADDR_BITS = 10,
    parameter int AMP_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LUT_ADDR_BITS-1:0] addr,
    output logic [AMP_WIDTH-1:0]     data
);

    localparam int unsigned DEPTH = 32'd1 << LUT_ADDR_BITS;
    localparam int unsigned QTR   = DEPTH / 32'd4;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;
    localparam longint AMP_PEAK    = (64'sd1 <<< (AMP_WIDTH - 1)) - 64'sd1;
    localparam longint MID_L       = 64'sd1 <<< (AMP_WIDTH - 1);
    localparam logic [AMP_WIDTH-1:0] MID = {1'b1, {(AMP_WIDTH-1){1'b0}}};

    // Integer Taylor series in Q30 over the first quadrant, mirrored into the other three.
    function automatic logic [AMP_WIDTH-1:0] sine_entry(input int unsigned idx);
        longint      x;
        longint      x2;
        longint      term;
        longint      acc;
        longint      mag;
        longint      res;
        int unsigned quad;
        int unsigned rem;
        int unsigned j;
        quad = (idx / QTR) % 32'd4;
        rem  = idx % QTR;
        j    = quad[0] ? (QTR - rem) : rem;
        x    = (longint'(j) * HALF_PI_Q30) / longint'(QTR);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        mag = (acc * AMP_PEAK + (64'sd1 <<< 29)) >>> 30;
        if (quad[1]) begin
            res = MID_L - mag;
        end else begin
            res = MID_L + mag;
        end
        return res[AMP_WIDTH-1:0];
    endfunction

    logic [AMP_WIDTH-1:0] table_s [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_table
        assign table_s[i] = sine_entry(i);
    end

    // Synchronous read; reset value equals the phase-0 entry so the output stays at midscale.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= MID;
        end else begin
            data <= table_s[addr];
        end
    end

endmodule

// File: rtl/dds_core.sv
// DDS generator: Hz-to-increment scaling, phase accumulator and two-stage waveform pipeline.
module dds_core
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH   = 24,
    parameter int AMP_WIDTH     = 12,
    parameter int LUT_ADDR_BITS = 10,
    parameter int FS_HZ         = 1_041_100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          freq_word,
    input  logic [2:0]           wave_sel,
    input  logic [AMP_WIDTH-1:0] dc_level,
    output logic [AMP_WIDTH-1:0] wave_out
);

    localparam longint unsigned K = calc_k(PHASE_WIDTH, longint'(FS_HZ));
    localparam int K_WIDTH = $clog2(K + 64'd1);
    localparam int PROD_W  = 16 + K_WIDTH;
    localparam logic [K_WIDTH-1:0]   K_VEC = K_WIDTH'(K);
    localparam logic [AMP_WIDTH-1:0] MID   = {1'b1, {(AMP_WIDTH-1){1'b0}}};

    logic [PROD_W-1:0]      prod_s;
    logic [PHASE_WIDTH-1:0] inc_s;
    logic [PHASE_WIDTH-1:0] inc_r;
    logic [PHASE_WIDTH-1:0] phase_r;
    logic [AMP_WIDTH:0]     top_s1_r;
    logic [2:0]             sel_s1_r;
    logic [AMP_WIDTH-1:0]   dc_s1_r;
    logic [AMP_WIDTH-1:0]   sine_s1;
    logic [AMP_WIDTH-1:0]   sample_s;

    assign prod_s = {{K_WIDTH{1'b0}}, freq_word} * {16'd0, K_VEC};
    assign inc_s  = PHASE_WIDTH'(prod_s >> 16);

    // Increment register and free-running phase accumulator (wraps silently).
    always_ff @(posedge clk) begin
        if (!rst) begin
            inc_r   <= {PHASE_WIDTH{1'b0}};
            phase_r <= {PHASE_WIDTH{1'b0}};
        end else begin
            inc_r   <= inc_s;
            phase_r <= phase_r + inc_r;
        end
    end

    dds_sine_rom #(
        .LUT_ADDR_BITS(LUT_ADDR_BITS),
        .AMP_WIDTH    (AMP_WIDTH)
    ) u_rom (
        .clk (clk),
        .rst (rst),
        .addr(phase_r[PHASE_WIDTH-1 -: LUT_ADDR_BITS]),
        .data(sine_s1)
    );

    // Stage 1: only the phase MSBs are needed by the non-sine shapes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            top_s1_r <= {(AMP_WIDTH+1){1'b0}};
            sel_s1_r <= 3'd0;
            dc_s1_r  <= {AMP_WIDTH{1'b0}};
        end else begin
            top_s1_r <= phase_r[PHASE_WIDTH-1 -: AMP_WIDTH+1];
            sel_s1_r <= wave_sel;
            dc_s1_r  <= dc_level;
        end
    end

    // Waveform shaping from the stage-1 values.
    always_comb begin
        sample_s = MID;
        case (wave_sel_e'(sel_s1_r))
            SINE:     sample_s = sine_s1;
            SQUARE:   sample_s = top_s1_r[AMP_WIDTH] ? {AMP_WIDTH{1'b0}} : {AMP_WIDTH{1'b1}};
            TRIANGLE: sample_s = top_s1_r[AMP_WIDTH] ? ~top_s1_r[AMP_WIDTH-1:0]
                                                     : top_s1_r[AMP_WIDTH-1:0];
            RAMP:     sample_s = top_s1_r[AMP_WIDTH:1];
            DC:       sample_s = dc_s1_r;
            default:  sample_s = MID;
        endcase
    end

    // Stage 2: registered output sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wave_out <= MID;
        end else begin
            wave_out <= sample_s;
        end
    end

endmodule

// File: tb/tb_dds_core.sv
// Scoreboard bench for dds_core: a cycle model pushes expected samples, a negedge monitor checks them.
module tb_dds_core;

    logic        clk;
    logic        rst;
    logic [15:0] freq_word;
    logic [2:0]  wave_sel;
    logic [11:0] dc_level;
    logic [11:0] wave_out;

    dds_core dut (
        .clk      (clk),
        .rst      (rst),
        .freq_word(freq_word),
        .wave_sel (wave_sel),
        .dc_level (dc_level),
        .wave_out (wave_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] val;
        int          tol;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    string cur_tag = "reset";
    int   sine_max = 0;
    int   sine_min = 4095;

    // Hand-derived round(2^40 / 1041100).
    localparam longint K_CONST = 64'sd1056106;
    localparam real    PI = 3.14159265358979;

    longint      m_inc;
    longint      m_phase;
    longint      m_p1;
    logic [2:0]  m_sel1;
    logic [11:0] m_dc1;

    function automatic logic [11:0] model_map(input logic [2:0] sel, input longint p,
                                              input logic [11:0] dc, output int tol);
        longint t;
        real    s;
        tol = 0;
        case (sel)
            3'd0: begin
                s   = $sin(2.0 * PI * real'(p / 16384) / 1024.0);
                tol = 1;
                return 12'($rtoi(2048.0 + 2047.0 * s + 0.5));
            end
            3'd1: return (p < 64'sd8388608) ? 12'd4095 : 12'd0;
            3'd2: begin
                t = p / 2048;
                if (t >= 4096) return 12'(4095 - (t - 4096));
                else return 12'(t);
            end
            3'd3: return 12'(p / 4096);
            3'd4: return dc;
            default: return 12'h800;
        endcase
    endfunction

    // One clock: advance the model on the edge the DUT sees, queue the expected output.
    task automatic cyc(input int n);
        exp_t e;
        int   tol;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            e.tag = cur_tag;
            if (!rst) begin
                e.val = 12'h800;
                e.tol = 0;
                m_inc = 0; m_phase = 0; m_p1 = 0; m_sel1 = 3'd0; m_dc1 = 12'd0;
            end else begin
                e.val   = model_map(m_sel1, m_p1, m_dc1, tol);
                e.tol   = tol;
                m_sel1  = wave_sel;
                m_dc1   = dc_level;
                m_p1    = m_phase;
                m_phase = (m_phase + m_inc) % 64'sd16777216;
                m_inc   = ((longint'(freq_word) * K_CONST) >> 16) % 64'sd16777216;
            end
            sb.push_back(e);
            #1;
        end
    endtask

    // Monitor: one output sample per clock, compared against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            int   d;
            e = sb.pop_front();
            d = int'(wave_out) - int'(e.val);
            if (d < 0) d = -d;
            checks++;
            if (d > e.tol) begin
                errors++;
                $display("FAIL %s: wave_out=%h expected=%h (tol %0d) at %0t",
                         e.tag, wave_out, e.val, e.tol, $time);
            end
            if (e.tag == "sine") begin
                if (int'(wave_out) > sine_max) sine_max = int'(wave_out);
                if (int'(wave_out) < sine_min) sine_min = int'(wave_out);
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b0; wave_sel = 3'd4; dc_level = 12'h123; freq_word = 16'd0;
        cur_tag = "reset";      cyc(10);
        rst = 1'b1;
        cur_tag = "dc_release"; cyc(4);
        dc_level = 12'h555;
        cur_tag = "dc_555";     cyc(6);
        dc_level = 12'hAAA;
        cur_tag = "dc_aaa";     cyc(6);
        freq_word = 16'd0; wave_sel = 3'd3;
        cur_tag = "hold_f0";    cyc(8);
        freq_word = 16'd10000;
        cur_tag = "ramp";       cyc(250);
        wave_sel = 3'd2;
        cur_tag = "triangle";   cyc(250);
        wave_sel = 3'd1; freq_word = 16'd25000;
        cur_tag = "square";     cyc(100);
        wave_sel = 3'd3; freq_word = 16'd5000;
        cur_tag = "ramp5k";     cyc(40);
        wave_sel = 3'd0;
        cur_tag = "sine";       cyc(260);
        for (int s = 5; s < 8; s++) begin
            wave_sel = 3'(s);
            cur_tag = "midscale"; cyc(3);
        end
        wave_sel = 3'd3; freq_word = 16'd65535;
        cur_tag = "alias";      cyc(20);
        rst = 1'b0;
        cur_tag = "reset_mid";  cyc(3);
        rst = 1'b1; wave_sel = 3'd0; freq_word = 16'd5000;
        cur_tag = "restart";    cyc(12);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #2;
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d samples pending, required 0", sb.size());
        end
        checks++;
        if (sine_max < 12'hFF0) begin
            errors++;
            $display("FAIL sine_max: got %h, required >= ff0", sine_max);
        end
        checks++;
        if (sine_min > 12'h010) begin
            errors++;
            $display("FAIL sine_min: got %h, required <= 010", sine_min);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
